// File: rtl/mul16_pkg.sv
// Shared types and constants for the 16x16 multiply scheduler and its 8x8 multiplier.
package mul16_pkg;

   localparam int unsigned NREQ   = 2;
   localparam int unsigned W_OP   = 16;
   localparam int unsigned W_PP   = 16;
   localparam int unsigned W_RES  = 32;
   localparam int unsigned W_HALF = W_OP / 2;
   localparam int unsigned SH_MID = 8;
   localparam int unsigned SH_HI  = 16;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_LL   = 3'd1;
   localparam logic [2:0] ST_HL   = 3'd2;
   localparam logic [2:0] ST_LH   = 3'd3;
   localparam logic [2:0] ST_HH   = 3'd4;
   localparam logic [2:0] ST_DONE = 3'd5;

   typedef enum logic [2:0] {
      IDLE = ST_IDLE,
      LL   = ST_LL,
      HL   = ST_HL,
      LH   = ST_LH,
      HH   = ST_HH,
      DONE = ST_DONE
   } state_t;

   typedef struct packed {
      logic [W_OP-1:0] a;
      logic [W_OP-1:0] b;
      logic            msb;
      logic            id;
   } op_t;

   function automatic logic [W_RES-1:0] pp_align(input logic [W_PP-1:0] pp,
                                                  input int unsigned     sh);
      return W_RES'(pp) << sh;
   endfunction

endpackage

// File: rtl/mul8x8.sv
// Combinational 8x8 unsigned multiplier; interchangeable with the hard multiplier macro.
module mul8x8
   import mul16_pkg::*;
(
   input  logic [W_HALF-1:0] a,
   input  logic [W_HALF-1:0] b,
   output logic [W_PP-1:0]   p
);

   always_comb begin
      p = W_PP'(a) * W_PP'(b);
   end

endmodule

// File: rtl/mul16_sched.sv
// Round-robin scheduler sharing one 8x8 multiplier across two requesters for 16x16 products.
// Optional: define MUL16_ZERO_SKIP_EN to bypass the partial-product sequence for zero operands.
module mul16_sched
   import mul16_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*W_OP-1:0]   req_a,
   input  logic [NREQ*W_OP-1:0]   req_b,
   input  logic [NREQ-1:0]        req_msb,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic                   rsp_id,
   output logic [W_RES-1:0]       rsp_data,
   output logic                   busy
);

   state_t            state;
   state_t            start_state;
   op_t               op;
   logic [W_RES-1:0]  acc;
   logic [W_RES-1:0]  acc_add;
   logic              rr_ptr;
   logic              grant;
   logic              any_req;
   logic [W_OP-1:0]   a_sel;
   logic [W_OP-1:0]   b_sel;
   logic              msb_sel;
   logic [W_HALF-1:0] mul_a;
   logic [W_HALF-1:0] mul_b;
   logic [W_PP-1:0]   pp;

   // The pointer's requester wins a tie; otherwise whichever one is valid.
   always_comb begin
      any_req = |req_valid;
      grant   = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
      a_sel   = grant ? req_a[2*W_OP-1:W_OP] : req_a[W_OP-1:0];
      b_sel   = grant ? req_b[2*W_OP-1:W_OP] : req_b[W_OP-1:0];
      msb_sel = req_msb[grant];
   end

   always_comb begin
      req_ready = '0;
      if (state == IDLE && any_req) begin
         req_ready[grant] = 1'b1;
      end
   end

`ifdef MUL16_ZERO_SKIP_EN
   always_comb begin
      start_state = ((a_sel == '0) || (b_sel == '0)) ? DONE : LL;
   end
`else
   always_comb begin
      start_state = LL;
   end
`endif

   always_comb begin
      mul_a = op.a[W_HALF-1:0];
      mul_b = op.b[W_HALF-1:0];
      case (state)
         HL: mul_a = op.a[W_OP-1:W_HALF];
         LH: mul_b = op.b[W_OP-1:W_HALF];
         HH: begin
            mul_a = op.a[W_OP-1:W_HALF];
            mul_b = op.b[W_OP-1:W_HALF];
         end
         default: ;
      endcase
   end

   mul8x8 u_mul (
      .a (mul_a),
      .b (mul_b),
      .p (pp)
   );

   always_comb begin
      acc_add = '0;
      case (state)
         LL:      acc_add = pp_align(pp, 0);
         HL, LH:  acc_add = pp_align(pp, SH_MID);
         HH:      acc_add = pp_align(pp, SH_HI);
         default: acc_add = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         op     <= '0;
         acc    <= '0;
         rr_ptr <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  op.a   <= a_sel;
                  op.b   <= b_sel;
                  op.msb <= msb_sel;
                  op.id  <= grant;
                  acc    <= '0;
                  rr_ptr <= ~grant;
                  state  <= start_state;
               end
            end
            LL: begin
               acc   <= acc + acc_add;
               state <= HL;
            end
            HL: begin
               acc   <= acc + acc_add;
               state <= LH;
            end
            LH: begin
               acc   <= acc + acc_add;
               state <= op.msb ? HH : DONE;
            end
            HH: begin
               acc   <= acc + acc_add;
               state <= DONE;
            end
            DONE: begin
               if (rsp_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Response fields come straight from registers, so they hold while DONE stalls.
   always_comb begin
      rsp_valid = (state == DONE);
      rsp_id    = op.id;
      rsp_data  = op.msb ? acc : {{(W_RES-W_OP){1'b0}}, acc[W_OP-1:0]};
      busy      = (state != IDLE);
   end

endmodule

// File: tb/tb_mul16_sched.sv
// Directed self-checking bench for mul16_sched (expects MUL16_ZERO_SKIP_EN to match the RTL build).
module tb_mul16_sched;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [1:0]  req_msb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [31:0] rsp_data;
   logic        busy;

   int n_chk = 0;
   int n_err = 0;
   int dual_ready_cnt = 0;

`ifdef MUL16_ZERO_SKIP_EN
   localparam int T6_LAT = 1;
`else
   localparam int T6_LAT = 5;
`endif

   mul16_sched dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_msb   (req_msb),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (req_ready === 2'b11) dual_ready_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge where rsp_valid is first seen.
   task automatic run_op(input string tag, input int r, input logic [15:0] a,
                         input logic [15:0] b, input logic msb, input int exp_lat,
                         input logic [31:0] exp_data);
      bit ok;
      int lat;
      req_a[r*16 +: 16] = a;
      req_b[r*16 +: 16] = b;
      req_msb[r]        = msb;
      req_valid[r]      = 1'b1;
      #1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (req_ready[r] === 1'b1) ok = 1'b1;
         else begin
            @(negedge clk);
            #1;
         end
      end
      check($sformatf("%s_accept", tag), 32'(ok), 32'd1);
      if (!ok) begin
         req_valid[r] = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      req_valid[r] = 1'b0;
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check($sformatf("%s_lat", tag), 32'(lat), 32'(exp_lat));
      check($sformatf("%s_data", tag), rsp_data, exp_data);
      check($sformatf("%s_id", tag), 32'(rsp_id), 32'(r));
   endtask

   initial begin
      int          nrsp;
      logic [31:0] rsp_ids [3];
      logic [31:0] rsp_dat [3];
      bit          ok;
      int          spurious;

      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_msb   = '0;
      rsp_ready = 1'b1;
      repeat (2) @(negedge clk);

      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
      check("rst_rsp_id", 32'(rsp_id), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Full-width product of the largest operands
      run_op("t1", 0, 16'hFFFF, 16'hFFFF, 1'b1, 5, 32'hFFFE0001);
      @(negedge clk);
      check("t1_idle_busy", 32'(busy), 32'd0);

      run_op("t2_lo", 1, 16'h1234, 16'h5678, 1'b0, 4, 32'h00000060);
      @(negedge clk);
      run_op("t2_full", 1, 16'h1234, 16'h5678, 1'b1, 5, 32'h06260060);
      @(negedge clk);

      // Round robin from reset with both requesters held valid
      rst_n = 1'b0;
      @(negedge clk);
      rst_n     = 1'b1;
      req_a     = {16'h0100, 16'h0003};
      req_b     = {16'h0100, 16'h0005};
      req_msb   = 2'b11;
      req_valid = 2'b11;
      nrsp = 0;
      for (int i = 0; i < 80 && nrsp < 3; i++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) begin
            rsp_ids[nrsp] = 32'(rsp_id);
            rsp_dat[nrsp] = rsp_data;
            nrsp++;
         end
      end
      req_valid = '0;
      check("t3_count", 32'(nrsp), 32'd3);
      if (nrsp == 3) begin
         check("t3_id0", rsp_ids[0], 32'd0);
         check("t3_id1", rsp_ids[1], 32'd1);
         check("t3_id2", rsp_ids[2], 32'd0);
         check("t3_data0", rsp_dat[0], 32'h0000000F);
         check("t3_data1", rsp_dat[1], 32'h00010000);
         check("t3_data2", rsp_dat[2], 32'h0000000F);
      end
      @(negedge clk);

      // Back-pressure in DONE with the other requester waiting
      rsp_ready = 1'b0;
      run_op("t4", 0, 16'h1234, 16'h5678, 1'b1, 5, 32'h06260060);
      req_valid[1] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         check($sformatf("t4_hold%0d_valid", k), 32'(rsp_valid), 32'd1);
         check($sformatf("t4_hold%0d_data", k), rsp_data, 32'h06260060);
         check($sformatf("t4_hold%0d_id", k), 32'(rsp_id), 32'd0);
         check($sformatf("t4_hold%0d_ready", k), 32'(req_ready), 32'd0);
         check($sformatf("t4_hold%0d_busy", k), 32'(busy), 32'd1);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("t4_idle_busy", 32'(busy), 32'd0);
      check("t4_idle_rsp_valid", 32'(rsp_valid), 32'd0);
      check("t4_idle_ready", 32'(req_ready), 32'b10);
      req_valid = '0;
      @(negedge clk);

      // Reset asserted while the HL step is in progress
      req_a[15:0] = 16'h00FF;
      req_b[15:0] = 16'h0100;
      req_msb[0]  = 1'b0;
      req_valid   = 2'b01;
      #1;
      ok = (req_ready === 2'b01);
      check("t5_accept", 32'(ok), 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      @(posedge clk);
      @(negedge clk);
      check("t5_busy_hl", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("t5_rst_rsp_data", rsp_data, 32'd0);
      check("t5_rst_rsp_id", 32'(rsp_id), 32'd0);
      check("t5_rst_req_ready", 32'(req_ready), 32'd0);
      check("t5_rst_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      spurious = 0;
      repeat (8) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0) spurious++;
      end
      check("t5_no_rsp", 32'(spurious), 32'd0);
      req_a     = {16'h0001, 16'h00FF};
      req_b     = {16'h0001, 16'h0100};
      req_valid = 2'b11;
      #1;
      check("t5_rr_ptr_reset", 32'(req_ready), 32'b01);
      req_valid = '0;
      run_op("t5_reissue", 0, 16'h00FF, 16'h0100, 1'b0, 4, 32'h0000FF00);
      @(negedge clk);

      run_op("t6_zero", 0, 16'h0000, 16'hABCD, 1'b1, T6_LAT, 32'h00000000);
      @(negedge clk);

      check("no_dual_ready", 32'(dual_ready_cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
